// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: MD opcodes and FSM states.
package mult_div_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, runs mult/div for a fixed
// number of busy cycles, and performs single-cycle mthi/mtlo/mfhi/mflo.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut,
  output md_state_e   state_o
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic [31:0]        div_b;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic               can_issue, accept;

  // Low 64 bits of a 64x64 product of extended operands are the exact 32x32 result.
  assign prod_s = {{32{SA[31]}}, SA} * {{32{SB[31]}}, SB};
  assign prod_u = {32'd0, SA} * {32'd0, SB};

  // Divisor is forced to 1 for the zero and overflow cases so the dividers never
  // see an undefined operation; those results are discarded or overridden.
  assign div_zero = (SB == 32'd0);
  assign div_ovf  = (SA == 32'h8000_0000) && (SB == 32'hFFFF_FFFF);
  assign div_b    = (div_zero || div_ovf) ? 32'd1 : SB;
  assign quo_s    = $signed(SA) / $signed(div_b);
  assign rem_s    = $signed(SA) % $signed(div_b);
  assign quo_u    = SA / div_b;
  assign rem_u    = SA % div_b;

  assign can_issue = Start && !Req && (state_q == ST_IDLE);
  assign accept    = can_issue && is_long_op(MDOp);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_RUN;
          pend_wr_d = 1'b1;
          if ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) cnt_d = CNT_W'(MULT_CYCLES);
          else                                         cnt_d = CNT_W'(DIV_CYCLES);
          case (MDOp)
            MD_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
            MD_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
            MD_DIV: begin
              if (div_ovf) begin
                pend_hi_d = 32'd0;
                pend_lo_d = 32'h8000_0000;
              end else begin
                pend_hi_d = rem_s;
                pend_lo_d = quo_s;
              end
              pend_wr_d = !div_zero;
            end
            default: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_wr_d = !div_zero;
            end
          endcase
        end else if (can_issue && (MDOp == MD_MTHI)) begin
          hi_d = SA;
        end else if (can_issue && (MDOp == MD_MTLO)) begin
          lo_d = SA;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Read port ignores Start: the decoder drives MDOp and the hazard unit guards staleness.
  always_comb begin
    MDOut = 32'd0;
    if (MDOp == MD_MFHI)      MDOut = hi_q;
    else if (MDOp == MD_MFLO) MDOut = lo_q;
  end

  assign Busy    = (state_q == ST_RUN);
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] sa = '0, sb = '0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, md_out;
  md_state_e   state;

  mult_div_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(start), .MDOp(md_op), .SA(sa), .SB(sb),
    .Req(req), .Busy(busy), .HI(hi), .LO(lo), .MDOut(md_out), .state_o(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_n;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one issued op on HI/LO.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic rq);
    longint          p;
    longint unsigned pu;
    int              ai, bi;
    if (rq) return;
    ai = int'(a);
    bi = int'(b);
    case (op)
      4'd1: begin p = longint'(ai) * longint'(bi); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin pu = longint'(a) * longint'(b); m_hi = pu[63:32]; m_lo = pu[31:0]; end
      4'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          m_lo = ai / bi; m_hi = ai % bi;
        end
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_len(input logic [3:0] op, input logic rq);
    if (rq) return 0;
    if (op == 4'd1 || op == 4'd2) return MULT_N;
    if (op == 4'd3 || op == 4'd4) return DIV_N;
    return 0;
  endfunction

  // Issue one op for one cycle, then count busy cycles (bounded) until idle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, output int n);
    @(negedge clk);
    start = 1'b1; md_op = op; sa = a; sb = b; req = rq;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0; req = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_rq;

    vecs[0]  = '{4'd7, 32'h1234, 32'd0, 1'b0, 32'h1234, 32'h0, 0};
    vecs[1]  = '{4'd8, 32'h1234, 32'd0, 1'b0, 32'h1234, 32'h1234, 0};
    vecs[2]  = '{4'd4, 32'd7, 32'd0, 1'b0, 32'h1234, 32'h1234, DIV_N};
    vecs[3]  = '{4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MULT_N};
    vecs[4]  = '{4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h1, 32'hFFFF_FFFE, MULT_N};
    vecs[5]  = '{4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[6]  = '{4'd1, 32'd2, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    vecs[7]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, DIV_N};
    vecs[8]  = '{4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h1, 32'hFFFF_FFFD, DIV_N};
    vecs[9]  = '{4'd0, 32'd9, 32'd9, 1'b0, 32'h1, 32'hFFFF_FFFD, 0};
    vecs[10] = '{4'd9, 32'd9, 32'd9, 1'b0, 32'h1, 32'hFFFF_FFFD, 0};
    vecs[11] = '{4'd5, 32'd9, 32'd9, 1'b0, 32'h1, 32'hFFFF_FFFD, 0};
    vecs[12] = '{4'd4, 32'hFFFF_FFFF, 32'd10, 1'b0, 32'h5, 32'h1999_9999, DIV_N};

    // Clock/reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, ST_IDLE);
    check("rst_mdout", md_out, 0);

    // Directed table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq, n);
      check($sformatf("vec%0d_busy_len", i), n, vecs[i].exp_n);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
      model_apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq);
    end

    // Randomized ops against the model
    for (int k = 0; k < 60; k++) begin
      r_op = 4'($urandom_range(0, 10));
      r_a  = $urandom();
      r_b  = $urandom();
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFF_FFFF;
        2: r_a = 32'h8000_0000;
        3: r_b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      r_rq = ($urandom_range(0, 7) == 0);
      issue(r_op, r_a, r_b, r_rq, n);
      model_apply(r_op, r_a, r_b, r_rq);
      check($sformatf("rnd%0d_busy_len", k), n, exp_len(r_op, r_rq));
      check($sformatf("rnd%0d_hi", k), hi, m_hi);
      check($sformatf("rnd%0d_lo", k), lo, m_lo);
    end

    // mtlo then mflo/mfhi readback
    issue(4'd8, 32'h0000_ABCD, 32'd0, 1'b0, n);
    model_apply(4'd8, 32'h0000_ABCD, 32'd0, 1'b0);
    md_op = 4'd6;
    #1 check("mflo_after_mtlo", md_out, 32'h0000_ABCD);
    @(negedge clk);
    md_op = 4'd5;
    #1 check("mfhi_read", md_out, m_hi);

    // Start during RUN (mthi) ignored; mfhi during RUN returns old HI
    @(negedge clk);
    start = 1'b1; md_op = 4'd3; sa = 32'd100; sb = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    @(negedge clk);
    start = 1'b1; md_op = 4'd7; sa = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; md_op = 4'd5;
    #1 check("mfhi_during_run", md_out, m_hi);
    n = 3;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    md_op = 4'd0;
    model_apply(4'd3, 32'd100, 32'd7, 1'b0);
    check("mid_mthi_busy_len", n, DIV_N + 1);
    check("mid_mthi_hi", hi, 32'd2);
    check("mid_mthi_lo", lo, 32'd14);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; md_op = 4'd3; sa = 32'd50; sb = 32'd3;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, m_hi);
    check("mid_rst_lo", lo, m_lo);
    check("mid_rst_state", state, ST_IDLE);
    repeat (DIV_N + 2) @(negedge clk);
    check("post_rst_hi", hi, 0);
    check("post_rst_lo", lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
